counter_stim_checker: RTL and testbench
=======================================

# counter_stim_checker

Synthesizable stimulus generator and self-checker for the 8-bit load/increment counter; it is the driving end of the counter interface (data_in, inc, ld, rst out; q back in). Commands arrive over a valid/ready port, are replayed onto the counter pins for a programmed number of cycles, and a cycle-accurate reference model compares the counter's q each cycle, counting and capturing mismatches. It sits between a test sequencer (or CPU register block) and the counter under test.

## Interface
- WIDTH, 8, counter data width (data_in, q, model)
- ERRW, 16, error counter width
- clk  in  1  single clock, all state on posedge
- rst  in  1  asynchronous, active-low block reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid & ready at posedge
- cmd_op  in  2  00 reset counter, 01 load, 10 increment, 11 idle (hold)
- cmd_data  in  WIDTH  load value (op 01 only)
- cmd_len  in  8  cycles to drive op; 0 treated as 1
- cntr_data_in  out  WIDTH  to counter data_in
- cntr_ld  out  1  to counter ld
- cntr_inc  out  1  to counter inc
- cntr_rst  out  1  to counter rst, active-high, synchronous at counter
- cntr_q  in  WIDTH  counter q
- busy  out  1  command in progress
- done  out  1  one-cycle pulse on command completion
- synced  out  1  model valid (a reset op has completed)
- mismatch  out  1  sticky, set on first compare failure
- err_cnt  out  ERRW  saturating mismatch count
- first_exp, first_act  out  WIDTH each  expected/actual at first mismatch

## Operation
- Counter contract modelled: priority rst > ld > inc; q registered; inc wraps 2^WIDTH-1 -> 0; no control -> hold.
- FSM: IDLE, DRIVE.
  - IDLE: cmd_ready=1, counter pins deasserted (ld=inc=rst=0, data_in holds last value). On accept: latch op/data, rem <= max(cmd_len,1), drive pins for op, -> DRIVE.
  - DRIVE: cmd_ready=0, busy=1; each posedge rem--; at edge where rem==1: deassert pins, done=1 next cycle, -> IDLE.
- Pins registered; all op cycles identical (load drives same data every cycle; idle op drives no controls).
- Model exp updated on every posedge from the registered pin values currently driven: cntr_rst -> 0 and synced<=1; else ld -> cntr_data_in; else inc -> exp+1 mod 2^WIDTH.
- Check: at each posedge with synced=1, compare cntr_q (pre-edge) with exp (pre-edge); unequal -> err_cnt++ (saturate at 2^ERRW-1); if mismatch==0 capture first_exp/first_act and set mismatch.
- Mismatch state cleared only by rst; counter-reset op does not clear it.
- cmd_valid while busy: ignored, must be held by source.

## Timing
- rst low (async): state IDLE, cntr_rst=1 (counter held in reset), cntr_ld=cntr_inc=0, cntr_data_in=0, exp=0, synced=0, busy=0, done=0, mismatch=0, err_cnt=0, first_exp=first_act=0, cmd_ready=0; cmd_ready=1 from first clk edge after release, cntr_rst=0 from that edge.
- Accept edge E0: pins active from E0 through E0+len; counter samples at E1..Elen; pins drop at Elen; done high for cycle following Elen.
- Minimum one idle cycle between commands; len=N command occupies N+1 cycles accept-to-accept.
- First compare occurs on edge after the counter-reset op's first sampled edge (synced just set).
- Async rst mid-command: abort immediately, all outputs to reset values, no done.

## Test plan
- Reset op len 1, then idle len 3 with correct counter -> synced=1, q=0 each cycle, err_cnt=0, done pulses twice.
- Load 0x5A len 1, increment len 10 -> exp/q reach 0x64, err_cnt=0, busy high exactly 1 and 10 cycles.
- Load 0xFE, increment len 3 -> wrap 0xFE,0xFF,0x00,0x01; no mismatch.
- Faulty counter ignores one inc after load 0x10 -> mismatch=1, first_exp=0x12, first_act=0x11, err_cnt increments every later cycle until reload.
- cmd_len=0 load 0x33 -> behaves as len 1; back-to-back valid held -> second accepted one cycle after done edge.
- Assert rst low mid increment len 20 -> outputs reset asynchronously, cntr_rst=1, synced=0, err_cnt=0, no done pulse.

Source files
------------

// File: rtl/counter_stim_checker_if.sv
// Command handshake between a test sequencer (master) and counter_stim_checker (slave).
// A command is accepted on a posedge where valid and ready are both high.
interface counter_stim_checker_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             valid;
    logic             ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] data;
    logic [7:0]       len;

    modport master (output valid, output op, output data, output len, input ready);
    modport slave  (input valid, input op, input data, input len, output ready);
endinterface

// File: rtl/counter_stim_checker.sv
// Replays accepted commands onto the load/increment counter pins for cmd.len cycles and
// checks the counter's q against a cycle-accurate model, capturing the first mismatch.
module counter_stim_checker #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ERRW  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    counter_stim_checker_if.slave cmd,
    output logic [WIDTH-1:0]      o_cntr_data_in,
    output logic                  o_cntr_ld,
    output logic                  o_cntr_inc,
    output logic                  o_cntr_rst,
    input  logic [WIDTH-1:0]      i_cntr_q,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_synced,
    output logic                  o_mismatch,
    output logic [ERRW-1:0]       o_err_cnt,
    output logic [WIDTH-1:0]      o_first_exp,
    output logic [WIDTH-1:0]      o_first_act
);
    typedef enum logic [0:0] {StIdle, StDrive} state_e;

    // Op 2'b11 (idle/hold) drives no control pins, so it needs no decode.
    localparam logic [1:0]      OpRst  = 2'b00;
    localparam logic [1:0]      OpLd   = 2'b01;
    localparam logic [1:0]      OpInc  = 2'b10;
    localparam logic [ERRW-1:0] ErrMax = '1;

    state_e           r_state;
    state_e           w_state_next;
    logic             r_started;
    logic [7:0]       r_rem;
    logic [WIDTH-1:0] r_cntr_data_in;
    logic             r_cntr_ld;
    logic             r_cntr_inc;
    logic             r_cntr_rst;
    logic             r_done;
    logic [WIDTH-1:0] r_exp;
    logic             r_synced;
    logic             r_mismatch;
    logic [ERRW-1:0]  r_err_cnt;
    logic [WIDTH-1:0] r_first_exp;
    logic [WIDTH-1:0] r_first_act;

    logic w_ready;
    logic w_busy;
    logic w_accept;
    logic w_last;
    logic w_cmp_fail;

    assign w_accept   = cmd.valid && w_ready;
    assign w_last     = (r_rem == 8'd1);
    assign w_cmp_fail = r_synced && (i_cntr_q != r_exp);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_next = StDrive;
            StDrive: if (w_last) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Ready stays low until the first edge after reset release.
    always_comb begin
        w_ready = r_started && (r_state == StIdle);
        w_busy  = (r_state == StDrive);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_started      <= 1'b0;
            r_rem          <= 8'd0;
            r_cntr_data_in <= '0;
            r_cntr_ld      <= 1'b0;
            r_cntr_inc     <= 1'b0;
            r_cntr_rst     <= 1'b1;
            r_done         <= 1'b0;
        end else begin
            r_started <= 1'b1;
            r_done    <= w_busy && w_last;
            if (w_accept) begin
                r_rem      <= (cmd.len == 8'd0) ? 8'd1 : cmd.len;
                r_cntr_rst <= (cmd.op == OpRst);
                r_cntr_ld  <= (cmd.op == OpLd);
                r_cntr_inc <= (cmd.op == OpInc);
                if (cmd.op == OpLd) begin
                    r_cntr_data_in <= cmd.data;
                end
            end else begin
                if (w_busy) begin
                    r_rem <= r_rem - 8'd1;
                end
                // Pins hold their op value for the whole command, then drop together.
                if (!w_busy || w_last) begin
                    r_cntr_rst <= 1'b0;
                    r_cntr_ld  <= 1'b0;
                    r_cntr_inc <= 1'b0;
                end
            end
        end
    end

    // Model tracks the pins the counter samples on this same edge, so exp and q stay aligned.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_exp       <= '0;
            r_synced    <= 1'b0;
            r_mismatch  <= 1'b0;
            r_err_cnt   <= '0;
            r_first_exp <= '0;
            r_first_act <= '0;
        end else begin
            if (r_cntr_rst) begin
                r_exp    <= '0;
                r_synced <= 1'b1;
            end else if (r_cntr_ld) begin
                r_exp <= r_cntr_data_in;
            end else if (r_cntr_inc) begin
                r_exp <= r_exp + WIDTH'(1);
            end
            if (w_cmp_fail) begin
                if (r_err_cnt != ErrMax) begin
                    r_err_cnt <= r_err_cnt + ERRW'(1);
                end
                if (!r_mismatch) begin
                    r_mismatch  <= 1'b1;
                    r_first_exp <= r_exp;
                    r_first_act <= i_cntr_q;
                end
            end
        end
    end

    assign cmd.ready      = w_ready;
    assign o_busy         = w_busy;
    assign o_done         = r_done;
    assign o_cntr_data_in = r_cntr_data_in;
    assign o_cntr_ld      = r_cntr_ld;
    assign o_cntr_inc     = r_cntr_inc;
    assign o_cntr_rst     = r_cntr_rst;
    assign o_synced       = r_synced;
    assign o_mismatch     = r_mismatch;
    assign o_err_cnt      = r_err_cnt;
    assign o_first_exp    = r_first_exp;
    assign o_first_act    = r_first_act;

endmodule

// File: tb/tb_counter_stim_checker.sv
// Bench for counter_stim_checker: a behavioural counter (with an optional skipped increment)
// sits on the pins, and command-level expectations are computed from the counter contract.
module tb_counter_stim_checker;
    localparam int ErrW = 6;
    localparam logic [1:0] OpRst  = 2'b00;
    localparam logic [1:0] OpLd   = 2'b01;
    localparam logic [1:0] OpInc  = 2'b10;
    localparam logic [1:0] OpIdle = 2'b11;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [7:0]      din;
    logic            ld, inc, crst;
    logic [7:0]      cntr_q;
    logic            busy, done, synced, mismatch;
    logic [ErrW-1:0] err_cnt;
    logic [7:0]      first_exp, first_act;

    int n_cmp = 0;
    int n_fail = 0;

    counter_stim_checker_if #(.WIDTH(8)) cmd_if ();

    counter_stim_checker #(.WIDTH(8), .ERRW(ErrW)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .cmd            (cmd_if),
        .o_cntr_data_in (din),
        .o_cntr_ld      (ld),
        .o_cntr_inc     (inc),
        .o_cntr_rst     (crst),
        .i_cntr_q       (cntr_q),
        .o_busy         (busy),
        .o_done         (done),
        .o_synced       (synced),
        .o_mismatch     (mismatch),
        .o_err_cnt      (err_cnt),
        .o_first_exp    (first_exp),
        .o_first_act    (first_act)
    );

    always #5 clk = ~clk;

    // Counter under test (q_bad, may skip the inc numbered skip_at) and an ideal twin.
    logic [7:0] q_bad = 8'h00;
    logic [7:0] q_gold = 8'h00;
    int inc_seen = 0;
    int skip_at = 0;
    int mis_edges = 0;

    always @(posedge clk) begin
        if (q_gold !== q_bad) mis_edges <= mis_edges + 1;
        if (crst) begin
            q_gold <= 8'h00;
            q_bad  <= 8'h00;
        end else if (ld) begin
            q_gold <= din;
            q_bad  <= din;
        end else if (inc) begin
            q_gold   <= q_gold + 8'd1;
            inc_seen <= inc_seen + 1;
            if (inc_seen + 1 != skip_at) q_bad <= q_bad + 8'd1;
        end
    end
    assign cntr_q = q_bad;

    logic [7:0] q_trace[$];

    task automatic send(input logic [1:0] op, input logic [7:0] data, input logic [7:0] len);
        int guard;
        guard = 0;
        cmd_if.valid = 1'b1;
        cmd_if.op    = op;
        cmd_if.data  = data;
        cmd_if.len   = len;
        while (!cmd_if.ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) begin
            n_cmp++; n_fail++;
            $display("FAIL send_timeout: ready got 0 after %0d cycles, want 1", guard);
        end
        @(posedge clk); #1;
        cmd_if.valid = 1'b0;
    endtask

    // Issue one command and wait for its done pulse; records q after every sampled edge.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] data, input logic [7:0] len,
                           output int busy_cyc, output int done_cnt);
        int guard;
        busy_cyc = 0;
        done_cnt = 0;
        guard = 0;
        q_trace.delete();
        send(op, data, len);
        while (done_cnt == 0 && guard < 300) begin
            if (busy) busy_cyc++;
            @(posedge clk); #1;
            guard++;
            q_trace.push_back(cntr_q);
            if (done) done_cnt++;
        end
        if (done_cnt == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL done_timeout: done got 0 after %0d cycles, want 1", guard);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({cmd_if.ready, crst, ld, inc, busy, done, synced, mismatch} !== 8'b0100_0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, want 01000000",
                     {cmd_if.ready, crst, ld, inc, busy, done, synced, mismatch});
        end
        n_cmp++;
        if ({din, err_cnt, first_exp, first_act} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h, want 0", {din, err_cnt, first_exp, first_act});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({cmd_if.ready, crst} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_release: ready,cntr_rst got %b, want 10", {cmd_if.ready, crst});
        end
    endtask

    task automatic test_reset_op();
        int b, d, dones;
        logic ok;
        run_cmd(OpRst, 8'h00, 8'd1, b, d);
        dones = d;
        n_cmp++;
        if (b != 1 || synced !== 1'b1) begin
            n_fail++;
            $display("FAIL rstop_busy_synced: got %0d/%b, want 1/1", b, synced);
        end
        run_cmd(OpIdle, 8'h00, 8'd3, b, d);
        dones += d;
        ok = (q_trace.size() == 3);
        foreach (q_trace[k]) if (q_trace[k] !== 8'h00) ok = 1'b0;
        n_cmp++;
        if (!ok || err_cnt !== '0) begin
            n_fail++;
            $display("FAIL idle_hold_zero: trace_ok got %b err %0d, want 1 err 0", ok, err_cnt);
        end
        n_cmp++;
        if (dones != 2) begin
            n_fail++;
            $display("FAIL done_count: got %0d, want 2", dones);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_width: got %b a cycle later, want 0", done);
        end
    endtask

    task automatic test_load_inc();
        int b, d;
        run_cmd(OpLd, 8'h5A, 8'd1, b, d);
        n_cmp++;
        if (b != 1 || cntr_q !== 8'h5A) begin
            n_fail++;
            $display("FAIL load_5a: busy %0d q %h, want 1 5a", b, cntr_q);
        end
        run_cmd(OpInc, 8'h00, 8'd10, b, d);
        n_cmp++;
        if (b != 10 || cntr_q !== 8'h64 || err_cnt !== '0) begin
            n_fail++;
            $display("FAIL inc_10: busy %0d q %h err %0d, want 10 64 0", b, cntr_q, err_cnt);
        end
    endtask

    task automatic test_wrap();
        int b, d;
        run_cmd(OpLd, 8'hFE, 8'd1, b, d);
        run_cmd(OpInc, 8'h00, 8'd3, b, d);
        n_cmp++;
        if (q_trace.size() != 3 || {q_trace[0], q_trace[1], q_trace[2]} !== 24'hFF0001 ||
            mismatch !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap: got trace size %0d mismatch %b, want FF,00,01 mismatch 0",
                     q_trace.size(), mismatch);
        end
    endtask

    task automatic test_len0_back_to_back();
        int b, d, gap, guard;
        run_cmd(OpLd, 8'h33, 8'd0, b, d);
        n_cmp++;
        if (b != 1 || cntr_q !== 8'h33) begin
            n_fail++;
            $display("FAIL len0: busy %0d q %h, want 1 33", b, cntr_q);
        end
        cmd_if.valid = 1'b1;
        cmd_if.op    = OpInc;
        cmd_if.data  = 8'h00;
        cmd_if.len   = 8'd2;
        guard = 0;
        while (!cmd_if.ready && guard < 50) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        cmd_if.op   = OpLd;
        cmd_if.data = 8'h77;
        cmd_if.len  = 8'd1;
        gap = 0;
        while (!cmd_if.ready && gap < 50) begin @(posedge clk); #1; gap++; end
        @(posedge clk); #1;
        cmd_if.valid = 1'b0;
        n_cmp++;
        if (gap + 1 != 3 || {ld, din} !== {1'b1, 8'h77}) begin
            n_fail++;
            $display("FAIL b2b_gap: got %0d cycles ld %b din %h, want 3 1 77", gap + 1, ld, din);
        end
        guard = 0;
        while (!done && guard < 50) begin @(posedge clk); #1; guard++; end
        n_cmp++;
        if (cntr_q !== 8'h77 || err_cnt !== '0) begin
            n_fail++;
            $display("FAIL b2b_result: q %h err %0d, want 77 0", cntr_q, err_cnt);
        end
    endtask

    task automatic test_random();
        int b, d, eff;
        logic [1:0] op;
        logic [7:0] data, len, mdl, want;
        logic ok;
        run_cmd(OpRst, 8'h00, 8'd1, b, d);
        mdl = 8'h00;
        for (int i = 0; i < 24; i++) begin
            op   = 2'($urandom_range(0, 3));
            data = 8'($urandom);
            len  = 8'($urandom_range(0, 12));
            eff  = (len == 0) ? 1 : int'(len);
            run_cmd(op, data, len, b, d);
            ok = (q_trace.size() == eff);
            foreach (q_trace[k]) begin
                case (op)
                    OpRst:   want = 8'h00;
                    OpLd:    want = data;
                    OpInc:   want = mdl + 8'(k + 1);
                    default: want = mdl;
                endcase
                if (q_trace[k] !== want) ok = 1'b0;
            end
            case (op)
                OpRst:   mdl = 8'h00;
                OpLd:    mdl = data;
                OpInc:   mdl = mdl + 8'(eff);
                default: mdl = mdl;
            endcase
            n_cmp++;
            if (b != eff || d != 1) begin
                n_fail++;
                $display("FAIL rnd%0d_timing: busy %0d done %0d, want %0d 1", i, b, d, eff);
            end
            n_cmp++;
            if (!ok) begin
                n_fail++;
                $display("FAIL rnd%0d_trace: op %0d len %0d trace_ok 0, want 1", i, op, len);
            end
            n_cmp++;
            if (cntr_q !== mdl || err_cnt !== '0 || mismatch !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd%0d_state: q %h err %0d mm %b, want %h 0 0",
                         i, cntr_q, err_cnt, mismatch, mdl);
            end
        end
    endtask

    task automatic test_fault();
        int b, d, base, e0, e1;
        base = mis_edges;
        skip_at = inc_seen + 2;
        run_cmd(OpLd, 8'h10, 8'd1, b, d);
        run_cmd(OpInc, 8'h00, 8'd6, b, d);
        n_cmp++;
        if ({mismatch, first_exp, first_act} !== {1'b1, 8'h12, 8'h11}) begin
            n_fail++;
            $display("FAIL fault_first: mm %b exp %h act %h, want 1 12 11",
                     mismatch, first_exp, first_act);
        end
        n_cmp++;
        if (int'(err_cnt) != 4 || int'(err_cnt) != mis_edges - base) begin
            n_fail++;
            $display("FAIL fault_err: got %0d, want 4 (golden %0d)", err_cnt, mis_edges - base);
        end
        e0 = int'(err_cnt);
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (int'(err_cnt) != e0 + 5) begin
            n_fail++;
            $display("FAIL fault_grow: got %0d, want %0d", err_cnt, e0 + 5);
        end
        run_cmd(OpLd, 8'h20, 8'd1, b, d);
        e1 = int'(err_cnt);
        n_cmp++;
        if (cntr_q !== 8'h20 || e1 != mis_edges - base) begin
            n_fail++;
            $display("FAIL reload: q %h err %0d, want 20 %0d", cntr_q, e1, mis_edges - base);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (int'(err_cnt) != e1) begin
            n_fail++;
            $display("FAIL reload_freeze: got %0d, want %0d", err_cnt, e1);
        end
        skip_at = inc_seen + 2;
        run_cmd(OpInc, 8'h00, 8'd2, b, d);
        repeat (70) @(posedge clk);
        #1;
        n_cmp++;
        if (err_cnt !== {ErrW{1'b1}}) begin
            n_fail++;
            $display("FAIL saturate: got %0d, want %0d", err_cnt, (1 << ErrW) - 1);
        end
        run_cmd(OpRst, 8'h00, 8'd1, b, d);
        n_cmp++;
        if ({mismatch, first_exp} !== {1'b1, 8'h12} || err_cnt !== {ErrW{1'b1}}) begin
            n_fail++;
            $display("FAIL sticky: mm %b exp %h err %0d, want 1 12 %0d",
                     mismatch, first_exp, err_cnt, (1 << ErrW) - 1);
        end
    endtask

    task automatic test_async_abort();
        logic seen_done, rst_dropped;
        send(OpInc, 8'h00, 8'd20);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({cmd_if.ready, crst, ld, inc, busy, done, synced, mismatch} !== 8'b0100_0000) begin
            n_fail++;
            $display("FAIL abort_ctrl: got %b, want 01000000",
                     {cmd_if.ready, crst, ld, inc, busy, done, synced, mismatch});
        end
        n_cmp++;
        if ({din, err_cnt, first_exp, first_act} !== 30'd0) begin
            n_fail++;
            $display("FAIL abort_data: got %h, want 0", {din, err_cnt, first_exp, first_act});
        end
        seen_done = 1'b0;
        rst_dropped = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
            if (!crst) rst_dropped = 1'b1;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        if (done) seen_done = 1'b1;
        n_cmp++;
        if (seen_done || rst_dropped || cmd_if.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_after: done %b rst_dropped %b ready %b, want 0 0 1",
                     seen_done, rst_dropped, cmd_if.ready);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_if.valid = 1'b0;
        cmd_if.op    = OpIdle;
        cmd_if.data  = 8'h00;
        cmd_if.len   = 8'd0;
        test_reset();
        test_reset_op();
        test_load_inc();
        test_wrap();
        test_len0_back_to_back();
        test_random();
        test_fault();
        test_async_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
